// File: rtl/writeback_stage.sv
// Writeback stage: retires one instruction per cycle into the register file write port,
// stalling on loads until lsu_rvalid and formatting the returned byte/half/word.
module writeback_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic             mem_rd_write,
    input  logic [4:0]       mem_rd_address,
    input  logic [XLEN-1:0]  mem_result,
    input  logic             mem_is_load,
    input  logic [2:0]       mem_funct3,
    input  logic [1:0]       mem_addr_low,
    input  logic             lsu_rvalid,
    input  logic [XLEN-1:0]  lsu_rdata,
    output logic [4:0]       rd_address,
    output logic [XLEN-1:0]  rd_data,
    output logic             fwd_valid,
    output logic [CNT_W-1:0] retire_count,
    output logic             err_funct3
);

    typedef enum logic {StIdle, StWaitLoad} state_e;

    state_e            state_q;
    logic [4:0]        rd_address_q;
    logic [XLEN-1:0]   rd_data_q;
    logic [CNT_W-1:0]  retire_count_q;
    logic              err_funct3_q;
    logic              pend_write_q;
    logic [4:0]        pend_address_q;
    logic [2:0]        pend_funct3_q;
    logic [1:0]        pend_low_q;

    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [XLEN-1:0]   load_data;
    logic              load_ok;

    // Format the load response using the fields captured at accept time.
    always_comb begin
        load_byte = 8'h00;
        unique case (pend_low_q)
            2'd0: load_byte = lsu_rdata[7:0];
            2'd1: load_byte = lsu_rdata[15:8];
            2'd2: load_byte = lsu_rdata[23:16];
            2'd3: load_byte = lsu_rdata[31:24];
            default: load_byte = 8'h00;
        endcase
        load_half = pend_low_q[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];
        load_ok   = 1'b1;
        load_data = '0;
        case (pend_funct3_q)
            3'b000: load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
            3'b001: load_data = {{(XLEN-16){load_half[15]}}, load_half};
            3'b010: load_data = lsu_rdata;
            3'b100: load_data = {{(XLEN-8){1'b0}}, load_byte};
            3'b101: load_data = {{(XLEN-16){1'b0}}, load_half};
            default: begin
                load_data = '0;
                load_ok   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            rd_address_q   <= '0;
            rd_data_q      <= '0;
            retire_count_q <= '0;
            err_funct3_q   <= 1'b0;
            pend_write_q   <= 1'b0;
            pend_address_q <= '0;
            pend_funct3_q  <= '0;
            pend_low_q     <= '0;
        end else begin
            // No completion this cycle unless overridden below; rd_data holds.
            rd_address_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (mem_valid) begin
                        if (mem_is_load) begin
                            pend_write_q   <= mem_rd_write;
                            pend_address_q <= mem_rd_address;
                            pend_funct3_q  <= mem_funct3;
                            pend_low_q     <= mem_addr_low;
                            state_q        <= StWaitLoad;
                        end else begin
                            rd_address_q   <= mem_rd_write ? mem_rd_address : 5'd0;
                            rd_data_q      <= mem_result;
                            retire_count_q <= retire_count_q + CNT_W'(1);
                        end
                    end
                end
                StWaitLoad: begin
                    if (lsu_rvalid) begin
                        rd_address_q   <= pend_write_q ? pend_address_q : 5'd0;
                        rd_data_q      <= load_data;
                        retire_count_q <= retire_count_q + CNT_W'(1);
                        if (!load_ok) begin
                            err_funct3_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_ready    = (state_q == StIdle);
    assign rd_address   = rd_address_q;
    assign rd_data      = rd_data_q;
    assign fwd_valid    = (rd_address_q != 5'd0);
    assign retire_count = retire_count_q;
    assign err_funct3   = err_funct3_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized and directed bench for writeback_stage against a behavioural model.
// A narrow retire counter is used so that wrap-around is reachable.
module tb_writeback_stage;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic          mem_rd_write = 1'b0;
    logic [4:0]    mem_rd_address = '0;
    logic [31:0]   mem_result = '0;
    logic          mem_is_load = 1'b0;
    logic [2:0]    mem_funct3 = '0;
    logic [1:0]    mem_addr_low = '0;
    logic          lsu_rvalid = 1'b0;
    logic [31:0]   lsu_rdata = '0;
    logic [4:0]    rd_address;
    logic [31:0]   rd_data;
    logic          fwd_valid;
    logic [CW-1:0] retire_count;
    logic          err_funct3;

    int checks = 0;
    int errors = 0;

    writeback_stage #(.XLEN(32), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_rd_write   (mem_rd_write),
        .mem_rd_address (mem_rd_address),
        .mem_result     (mem_result),
        .mem_is_load    (mem_is_load),
        .mem_funct3     (mem_funct3),
        .mem_addr_low   (mem_addr_low),
        .lsu_rvalid     (lsu_rvalid),
        .lsu_rdata      (lsu_rdata),
        .rd_address     (rd_address),
        .rd_data        (rd_data),
        .fwd_valid      (fwd_valid),
        .retire_count   (retire_count),
        .err_funct3     (err_funct3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Load formatting written as plain arithmetic on the returned word.
    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] low,
                                        input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * int'(low))) & 32'hFF;
        h = (w >> (16 * int'(low >> 1))) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
            3'd1: return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
            3'd2: return w;
            3'd4: return b;
            3'd5: return h;
            default: return 32'd0;
        endcase
    endfunction

    // Model: a stage is either free or holding one outstanding load.
    bit            m_busy = 0;
    logic          m_w = 0;
    logic [4:0]    m_a = '0;
    logic [2:0]    m_f3 = '0;
    logic [1:0]    m_low = '0;
    logic [4:0]    exp_addr = '0;
    logic [31:0]   exp_data = '0;
    int unsigned   exp_retired = 0;
    bit            exp_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_w = 0; m_a = '0; m_f3 = '0; m_low = '0;
            exp_addr = '0; exp_data = '0; exp_retired = 0; exp_err = 0;
        end else begin
            exp_addr = '0;
            if (!m_busy) begin
                if (mem_valid && mem_is_load) begin
                    m_busy = 1; m_w = mem_rd_write; m_a = mem_rd_address;
                    m_f3 = mem_funct3; m_low = mem_addr_low;
                end else if (mem_valid) begin
                    exp_addr = mem_rd_write ? mem_rd_address : 5'd0;
                    exp_data = mem_result;
                    exp_retired++;
                end
            end else if (lsu_rvalid) begin
                exp_addr = m_w ? m_a : 5'd0;
                exp_data = fmt(m_f3, m_low, lsu_rdata);
                if (!(m_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) exp_err = 1;
                exp_retired++;
                m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("mem_ready", {63'd0, mem_ready}, {63'd0, !m_busy});
        chk("rd_address", {59'd0, rd_address}, {59'd0, exp_addr});
        chk("rd_data", {32'd0, rd_data}, {32'd0, exp_data});
        chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, exp_addr != 5'd0});
        chk("retire_count", {56'd0, retire_count}, 64'(exp_retired % (1 << CW)));
        chk("err_funct3", {63'd0, err_funct3}, {63'd0, exp_err});
    end

    task automatic wait_ready();
        int n = 0;
        while (!mem_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!mem_ready) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_alu(input logic w, input logic [4:0] a, input logic [31:0] res);
        wait_ready();
        mem_valid = 1; mem_is_load = 0; mem_rd_write = w; mem_rd_address = a;
        mem_result = res; mem_funct3 = 3'($urandom); mem_addr_low = 2'($urandom);
        lsu_rvalid = 1'($urandom); lsu_rdata = $urandom;
        @(posedge clk); #1;
        mem_valid = 0; lsu_rvalid = 0;
    endtask

    // Accept a load, spend 'delay' cycles waiting with mem_valid held, rvalid in the last.
    task automatic do_load(input logic w, input logic [4:0] a, input logic [2:0] f3,
                           input logic [1:0] low, input int delay, input logic [31:0] rdata,
                           input bit lit);
        wait_ready();
        mem_valid = 1; mem_is_load = 1; mem_rd_write = w; mem_rd_address = a;
        mem_funct3 = f3; mem_addr_low = low; mem_result = $urandom;
        lsu_rvalid = 1'($urandom); lsu_rdata = $urandom;
        @(posedge clk); #1;
        lsu_rvalid = 0;
        for (int i = 1; i <= delay; i++) begin
            if (lit) begin
                chk("lit_wait_ready", {63'd0, mem_ready}, 64'd0);
                chk("lit_wait_rd_address", {59'd0, rd_address}, 64'd0);
            end
            if (i == delay) begin
                lsu_rvalid = 1; lsu_rdata = rdata;
            end
            @(posedge clk); #1;
        end
        lsu_rvalid = 0; mem_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        #22 rst_n = 1;
        #1;
        chk("lit_reset_ready", {63'd0, mem_ready}, 64'd1);
        chk("lit_reset_count", {56'd0, retire_count}, 64'd0);
        chk("lit_reset_rd_address", {59'd0, rd_address}, 64'd0);
        @(posedge clk); #1;

        // Reset while a load is outstanding discards it.
        mem_valid = 1; mem_is_load = 1; mem_rd_write = 1; mem_rd_address = 5'd9;
        mem_funct3 = 3'd2; mem_addr_low = 0;
        @(posedge clk); #1;
        mem_valid = 0;
        chk("lit_t1_busy", {63'd0, mem_ready}, 64'd0);
        do_reset();
        lsu_rvalid = 1; lsu_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        lsu_rvalid = 0;
        chk("lit_t1_rd_address", {59'd0, rd_address}, 64'd0);
        chk("lit_t1_count", {56'd0, retire_count}, 64'd0);
        chk("lit_t1_ready", {63'd0, mem_ready}, 64'd1);

        // Back-to-back ALU retirements.
        do_alu(1, 5'd1, 32'd5);
        chk("lit_t2_a1", {32'd0, 27'd0, rd_address, rd_data}, {32'd0, 27'd1, 32'd5});
        do_alu(1, 5'd2, 32'd6);
        chk("lit_t2_a2", {32'd0, 27'd0, rd_address, rd_data}, {32'd0, 27'd2, 32'd6});
        do_alu(1, 5'd3, 32'd7);
        chk("lit_t2_a3", {32'd0, 27'd0, rd_address, rd_data}, {32'd0, 27'd3, 32'd7});
        chk("lit_t2_count", {56'd0, retire_count}, 64'd3);

        do_load(1, 5'd4, 3'b000, 2'd3, 1, 32'h80FF_0000, 1);
        chk("lit_lb", {32'd0, rd_data}, 64'hFFFF_FF80);
        chk("lit_lb_addr", {59'd0, rd_address}, 64'd4);
        do_load(1, 5'd4, 3'b100, 2'd3, 1, 32'h80FF_0000, 1);
        chk("lit_lbu", {32'd0, rd_data}, 64'h0000_0080);
        do_load(1, 5'd5, 3'b001, 2'd2, 1, 32'h8001_1234, 1);
        chk("lit_lh", {32'd0, rd_data}, 64'hFFFF_8001);
        do_load(1, 5'd5, 3'b101, 2'd2, 1, 32'h8001_1234, 1);
        chk("lit_lhu", {32'd0, rd_data}, 64'h0000_8001);

        // Slow load response, then the next instruction goes straight in.
        do_load(1, 5'd7, 3'b010, 2'd0, 4, 32'h1234_5678, 1);
        chk("lit_lw_slow", {27'd0, rd_address, rd_data}, {27'd0, 5'd7, 32'h1234_5678});
        do_alu(1, 5'd8, 32'hCAFE_0001);
        chk("lit_after_slow", {27'd0, rd_address, rd_data}, {27'd0, 5'd8, 32'hCAFE_0001});
        chk("lit_count_9", {56'd0, retire_count}, 64'd9);

        // Random mix of ALU ops, loads, idle cycles and stray rvalid pulses.
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            r = $urandom_range(0, 3);
            if (r == 0) begin
                mem_valid = 0; lsu_rvalid = 1'($urandom);
                @(posedge clk); #1;
                lsu_rvalid = 0;
            end else if (r == 1) begin
                do_load(1'($urandom), 5'($urandom), 3'($urandom), 2'($urandom),
                        $urandom_range(1, 3), $urandom, 0);
            end else begin
                do_alu(1'($urandom), 5'($urandom), $urandom);
            end
        end

        // Counter wrap combined with an unsupported load type.
        do_reset();
        for (int n = 0; n < 255; n++) do_alu(1'($urandom), 5'($urandom), $urandom);
        chk("lit_count_max", {56'd0, retire_count}, 64'hFF);
        do_load(1, 5'd6, 3'b011, 2'd1, 1, 32'hFFFF_FFFF, 1);
        chk("lit_bad_data", {32'd0, rd_data}, 64'd0);
        chk("lit_bad_addr", {59'd0, rd_address}, 64'd6);
        chk("lit_bad_err", {63'd0, err_funct3}, 64'd1);
        chk("lit_wrap", {56'd0, retire_count}, 64'd0);
        do_alu(1, 5'd10, 32'd1);
        chk("lit_err_sticky", {63'd0, err_funct3}, 64'd1);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
